// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier / accumulator slice.
// Holds the default operand width, the accumulator state encoding and
// helpers for the signed extremes of a given bit width.
package booth_pkg;

  // Operand width of the upstream Booth multiplier; products are twice this.
  localparam int MUL_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Largest signed value representable in w bits.
  function automatic longint smax(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in w bits.
  function automatic longint smin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/booth_mac_acc_if.sv
// Product-in / group-result-out bus of booth_mac_acc.
// master = producer/consumer side, slave = accumulator side.
interface booth_mac_acc_if
  import booth_pkg::*;
#(
  parameter int MUL_W   = MUL_W_DEF,
  parameter int ACC_W   = 12,
  parameter int MAX_LEN = 8
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic                      prod_valid;
  logic                      prod_ready;
  logic signed [2*MUL_W-1:0] prod_data;
  logic                      prod_last;
  logic                      acc_valid;
  logic                      acc_ready;
  logic signed [ACC_W-1:0]   acc_data;
  logic [CNT_W-1:0]          acc_count;
  logic                      acc_ovf;

  modport master (
    output prod_valid, prod_data, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );
endinterface

// File: rtl/booth_acc_add.sv
// Combinational sign-extend and ACC_W-bit add with signed overflow detect.
// Optional build macro: BOOTH_ACC_SAT_EN clamps the sum to the signed
// extreme on overflow; without it the sum wraps in two's complement.
module booth_acc_add
  import booth_pkg::*;
#(
  parameter int MUL_W = MUL_W_DEF,
  parameter int ACC_W = 12
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [2*MUL_W-1:0] prod,
  output logic signed [ACC_W-1:0]   sum,
  output logic                      ovf
);
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] raw;

  // Size cast of a signed operand replicates its sign bit.
  assign prod_ext = ACC_W'(prod);
  assign raw      = acc + prod_ext;
  // Like-signed operands producing an opposite-signed result.
  assign ovf      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(smax(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(smin(ACC_W));

  // Clamp toward the sign both operands shared when the add overflowed.
  function automatic logic signed [ACC_W-1:0] saturate(
    input logic signed [ACC_W-1:0] r,
    input logic                    o,
    input logic                    neg
  );
    if (o) return neg ? SAT_MIN : SAT_MAX;
    return r;
  endfunction

  assign sum = saturate(raw, ovf, acc[ACC_W-1]);
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_mac_acc.sv
// Group accumulator for signed Booth products.
// Takes one product per valid/ready beat, closes a group on prod_last or
// after MAX_LEN beats, then holds sum/count/overflow until acc_ready.
// Optional build macro: BOOTH_ACC_SAT_EN (saturating accumulation,
// implemented inside booth_acc_add).
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int MUL_W   = MUL_W_DEF,
  parameter int ACC_W   = 12,
  parameter int MAX_LEN = 8
) (
  input logic          clk,
  input logic          rst_n,
  booth_mac_acc_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    ovf;
  logic                    add_ovf;
  logic                    take;
  logic                    close;

  // acc is zero in IDLE, so the first beat of a group is a plain load.
  booth_acc_add #(
    .MUL_W (MUL_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc  (acc),
    .prod (bus.prod_data),
    .sum  (sum),
    .ovf  (add_ovf)
  );

  // Handshake flags decode state only; rst_n gating keeps ready low during reset.
  assign bus.prod_ready = rst_n && (state != HOLD);
  assign bus.acc_valid  = (state == HOLD);
  assign bus.acc_data   = acc;
  assign bus.acc_count  = cnt;
  assign bus.acc_ovf    = ovf;

  assign take    = bus.prod_valid && (state != HOLD);
  assign cnt_nxt = cnt + 1'b1;
  assign close   = bus.prod_last || (cnt_nxt == CNT_W'(MAX_LEN));

  // Group state machine with accumulator, count and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (take) begin
            acc   <= sum;
            cnt   <= cnt_nxt;
            ovf   <= ovf | add_ovf;
            state <= close ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: one 12-bit and one 8-bit accumulator driven by
// the same product stream, checked against an integer reference model.
// Honors BOOTH_ACC_SAT_EN the same way the design does.
module tb_booth_mac_acc;
  logic clk;
  logic rst_n;
  logic pv;
  logic signed [5:0] pd;
  logic pl;
  logic ar;
  int total;
  int bad;

`ifdef BOOTH_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  booth_mac_acc_if #(.MUL_W(3), .ACC_W(12), .MAX_LEN(8)) bus12 ();
  booth_mac_acc_if #(.MUL_W(3), .ACC_W(8),  .MAX_LEN(8)) bus8 ();

  assign bus12.prod_valid = pv;
  assign bus12.prod_data  = pd;
  assign bus12.prod_last  = pl;
  assign bus12.acc_ready  = ar;
  assign bus8.prod_valid  = pv;
  assign bus8.prod_data   = pd;
  assign bus8.prod_last   = pl;
  assign bus8.acc_ready   = ar;

  booth_mac_acc #(.MUL_W(3), .ACC_W(12), .MAX_LEN(8)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));
  booth_mac_acc #(.MUL_W(3), .ACC_W(8),  .MAX_LEN(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Group sum as a sequence of integer additions in a w-bit signed range.
  function automatic void model(input int p[$], input int w, output int s, output bit o);
    int lo;
    int hi;
    int t;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    s = 0;
    o = 1'b0;
    foreach (p[i]) begin
      t = s + p[i];
      if (t > hi || t < lo) begin
        o = 1'b1;
        if (SAT) t = (t > hi) ? hi : lo;
        else     t = (t > hi) ? t - (1 << w) : t + (1 << w);
      end
      s = t;
    end
  endfunction

  // Presents each product until it is taken; returns aligned just after the accepting edge.
  task automatic send_group(input int p[$], input bit last_flag, input int gap, output bit tmo);
    bit r;
    int n;
    tmo = 1'b0;
    @(posedge clk); #1;
    foreach (p[i]) begin
      pv = 1'b0;
      repeat ($urandom_range(0, gap)) begin
        pl = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      pv = 1'b1;
      pd = 6'(p[i]);
      pl = last_flag && (i == p.size() - 1);
      n = 0;
      forever begin
        @(negedge clk); r = bus12.prod_ready;
        @(posedge clk); #1;
        if (r) break;
        n++;
        if (n > 50) begin tmo = 1'b1; break; end
      end
      if (tmo) break;
    end
    pv = 1'b0;
    pl = 1'b0;
  endtask

  task automatic test_reset();
    int p[$];
    bit tmo;
    @(negedge clk);
    if ({bus12.prod_ready, bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf} !== 18'd0) begin
      bad++; $display("FAIL reset_hold got rdy=%0b vld=%0b data=%0d need all 0", bus12.prod_ready, bus12.acc_valid, bus12.acc_data);
    end
    total++;
    rst_n = 1'b1;
    @(negedge clk);
    if ({bus12.prod_ready, bus8.prod_ready, bus12.acc_valid} !== 3'b110) begin
      bad++; $display("FAIL reset_release got rdy=%0b/%0b vld=%0b need 1/1/0", bus12.prod_ready, bus8.prod_ready, bus12.acc_valid);
    end
    total++;
    p = '{5, 6};
    send_group(p, 1'b0, 0, tmo);
    #2 rst_n = 1'b0;
    #1;
    if (tmo || {bus12.prod_ready, bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf,
                bus8.acc_data, bus8.acc_count, bus8.acc_ovf} !== 31'd0) begin
      bad++; $display("FAIL reset_midgroup got rdy=%0b vld=%0b data=%0d cnt=%0d data8=%0d tmo=%0b need 0",
                      bus12.prod_ready, bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus8.acc_data, tmo);
    end
    total++;
    @(negedge clk);
    rst_n = 1'b1;
    p = '{4};
    send_group(p, 1'b1, 0, tmo);
    @(negedge clk);
    if (tmo || {bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf} !== {1'b1, 12'sd4, 4'd1, 1'b0}) begin
      bad++; $display("FAIL reset_fresh got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 4 1 0",
                      bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf);
    end
    total++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int p[$];
    bit tmo;
    p = '{3, -2, 5};
    send_group(p, 1'b1, 0, tmo);
    @(negedge clk);
    if (tmo || {bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf} !== {1'b1, 12'sd6, 4'd3, 1'b0}) begin
      bad++; $display("FAIL basic_w12 got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 6 3 0",
                      bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf);
    end
    total++;
    if ({bus8.acc_valid, bus8.acc_data, bus8.acc_count, bus8.acc_ovf} !== {1'b1, 8'sd6, 4'd3, 1'b0}) begin
      bad++; $display("FAIL basic_w8 got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 6 3 0",
                      bus8.acc_valid, bus8.acc_data, bus8.acc_count, bus8.acc_ovf);
    end
    total++;
    @(negedge clk);
    if ({bus12.acc_valid, bus12.prod_ready, bus12.acc_data} !== {1'b0, 1'b1, 12'sd0}) begin
      bad++; $display("FAIL basic_idle got vld=%0b rdy=%0b data=%0d need 0 1 0", bus12.acc_valid, bus12.prod_ready, bus12.acc_data);
    end
    total++;
  endtask

  task automatic test_backpressure();
    int p[$];
    bit tmo;
    ar = 1'b0;
    p = '{1, 2};
    send_group(p, 1'b1, 0, tmo);
    pv = 1'b1; pd = 6'sd7; pl = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tmo || {bus12.prod_ready, bus12.acc_valid, bus12.acc_data, bus12.acc_count} !== {1'b0, 1'b1, 12'sd3, 4'd2}) begin
        bad++; $display("FAIL bp_hold%0d got rdy=%0b vld=%0b data=%0d cnt=%0d need 0 1 3 2",
                        k, bus12.prod_ready, bus12.acc_valid, bus12.acc_data, bus12.acc_count);
      end
      total++;
    end
    ar = 1'b1;
    @(posedge clk); #1;
    if ({bus12.acc_valid, bus12.prod_ready, bus12.acc_data} !== {1'b0, 1'b1, 12'sd0}) begin
      bad++; $display("FAIL bp_release got vld=%0b rdy=%0b data=%0d need 0 1 0", bus12.acc_valid, bus12.prod_ready, bus12.acc_data);
    end
    total++;
    @(posedge clk); #1;
    pv = 1'b0; pl = 1'b0;
    @(negedge clk);
    if ({bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus8.acc_data} !== {1'b1, 12'sd7, 4'd1, 8'sd7}) begin
      bad++; $display("FAIL bp_next got vld=%0b data=%0d cnt=%0d data8=%0d need 1 7 1 7",
                      bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus8.acc_data);
    end
    total++;
    @(negedge clk);
  endtask

  task automatic test_auto_close();
    int p[$];
    bit tmo;
    logic signed [7:0] want8;
    want8 = SAT ? 8'sd127 : -8'sd128;
    p = '{16, 16, 16, 16, 16, 16, 16, 16};
    send_group(p, 1'b0, 0, tmo);
    @(negedge clk);
    if (tmo || {bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf} !== {1'b1, 12'sd128, 4'd8, 1'b0}) begin
      bad++; $display("FAIL auto_w12 got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 128 8 0",
                      bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf);
    end
    total++;
    if ({bus8.acc_valid, bus8.acc_data, bus8.acc_count, bus8.acc_ovf} !== {1'b1, want8, 4'd8, 1'b1}) begin
      bad++; $display("FAIL auto_w8_ovf got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 %0d 8 1",
                      bus8.acc_valid, bus8.acc_data, bus8.acc_count, bus8.acc_ovf, want8);
    end
    total++;
    @(negedge clk);
  endtask

  task automatic test_negative();
    int p[$];
    bit tmo;
    p = '{-12, -12};
    send_group(p, 1'b1, 1, tmo);
    @(negedge clk);
    if (tmo || {bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf} !== {1'b1, -12'sd24, 4'd2, 1'b0}) begin
      bad++; $display("FAIL neg_w12 got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 -24 2 0",
                      bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf);
    end
    total++;
    if ({bus8.acc_data, bus8.acc_ovf} !== {-8'sd24, 1'b0}) begin
      bad++; $display("FAIL neg_w8 got data=%0d ovf=%0b need -24 0", bus8.acc_data, bus8.acc_ovf);
    end
    total++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int p[$];
    int len;
    int s12, s8;
    bit o12, o8;
    bit tmo;
    bit lst;
    for (int g = 0; g < 30; g++) begin
      len = $urandom_range(1, 8);
      p.delete();
      for (int i = 0; i < len; i++) p.push_back(int'($urandom_range(0, 63)) - 32);
      lst = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      model(p, 12, s12, o12);
      model(p, 8, s8, o8);
      send_group(p, lst, 2, tmo);
      @(negedge clk);
      if (tmo || {bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf} !== {1'b1, 12'(s12), 4'(len), o12}) begin
        bad++; $display("FAIL rand%0d_w12 got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 %0d %0d %0b",
                        g, bus12.acc_valid, bus12.acc_data, bus12.acc_count, bus12.acc_ovf, s12, len, o12);
      end
      total++;
      if ({bus8.acc_valid, bus8.acc_data, bus8.acc_count, bus8.acc_ovf} !== {1'b1, 8'(s8), 4'(len), o8}) begin
        bad++; $display("FAIL rand%0d_w8 got vld=%0b data=%0d cnt=%0d ovf=%0b need 1 %0d %0d %0b",
                        g, bus8.acc_valid, bus8.acc_data, bus8.acc_count, bus8.acc_ovf, s8, len, o8);
      end
      total++;
      if (!ar) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if ({bus8.acc_valid, bus8.acc_data, bus8.acc_ovf, bus12.prod_ready} !== {1'b1, 8'(s8), o8, 1'b0}) begin
          bad++; $display("FAIL rand%0d_stall got vld=%0b data=%0d ovf=%0b rdy=%0b need 1 %0d %0b 0",
                          g, bus8.acc_valid, bus8.acc_data, bus8.acc_ovf, bus12.prod_ready, s8, o8);
        end
        total++;
        ar = 1'b1;
      end
      @(negedge clk);
      if (bus12.acc_valid !== 1'b0) begin
        bad++; $display("FAIL rand%0d_done got vld=%0b need 0", g, bus12.acc_valid);
      end
      total++;
    end
    ar = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pv    = 1'b0;
    pd    = '0;
    pl    = 1'b0;
    ar    = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_auto_close();
    test_negative();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
